// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the odd-pipe branch resolution slice.
// Contents:
//   - unit-code constants used by the execution pipes
//   - brc_state_t : branch resolve controller states
//   - odd_rec_t   : odd-pipe final-stage record layout shared by producer/consumer
//   - is_unit     : helper comparing a record unit code against an id
package branch_resolve_ctrl_pkg;

  localparam int PKG_PC_W  = 15;
  localparam int FCNT_W    = 3;   // flush counter width, FLUSH_CYCLES in 1..7

  localparam logic [2:0] UNIT_SIMPLE_FX = 3'd0;
  localparam logic [2:0] UNIT_SIMPLE_BY = 3'd1;
  localparam logic [2:0] UNIT_PERM      = 3'd2;
  localparam logic [2:0] UNIT_SP_FP     = 3'd3;
  localparam logic [2:0] UNIT_LS        = 3'd4;
  localparam logic [2:0] UNIT_BYTE      = 3'd5;
  localparam logic [2:0] UNIT_FX2       = 3'd6;
  localparam logic [2:0] BRANCH_UNIT    = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } brc_state_t;

  typedef struct packed {
    logic [2:0]          unit;
    logic [3:0]          latency;
    logic                wr_en;
    logic [6:0]          addr;
    logic [127:0]        data;
    logic [PKG_PC_W-1:0] pc;
    logic                br_flag;
  } odd_rec_t;

  function automatic logic is_unit(input logic [2:0] unit, input logic [2:0] id);
    return (unit == id);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// Saturating up-counter used for branch statistics.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset, clears the count
//   inc   - increment request for this cycle
//   count - current count, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;

  // Count up on request, holding once every bit is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {W{1'b0}};
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller downstream of the odd pipe.
// Taken branches cause a FLUSH_CYCLES-long flush of both pipes with fetch
// stalled, followed by a redirect to fetch held until acknowledged. A stop
// opcode seen while idle parks the block in a sticky halt.
// Ports:
//   clk, reset      - clock (rising) and async active-high reset
//   rec_valid       - odd-pipe final-stage record valid
//   rec_unit        - unit code of the record
//   rec_br_flag     - branch taken
//   rec_target      - branch target PC
//   rec_stop        - stop opcode reached final stage
//   redirect_ack    - fetch accepted the redirect
//   flush           - flush to even and odd pipes
//   fetch_stall     - freeze fetch/issue
//   redirect_valid  - redirect request to fetch
//   redirect_pc     - new fetch PC, word aligned
//   halted          - sticky stop indication
//   taken_cnt       - taken-branch count (saturating)
//   nottaken_cnt    - not-taken-branch count (saturating)
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int             PC_W           = 15,
  parameter int             FLUSH_CYCLES   = 3,
  parameter logic [2:0]     BRANCH_UNIT_ID = BRANCH_UNIT,
  parameter int             CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rec_valid,
  input  logic [2:0]       rec_unit,
  input  logic             rec_br_flag,
  input  logic [PC_W-1:0]  rec_target,
  input  logic             rec_stop,
  input  logic             redirect_ack,
  output logic             flush,
  output logic             fetch_stall,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);

  brc_state_t        state_q;
  logic [FCNT_W-1:0] flush_cnt_q;
  logic [PC_W-1:0]   target_q;
  logic              flush_q;
  logic              fetch_stall_q;
  logic              redirect_valid_q;
  logic              halted_q;

  logic              is_branch_s;
  logic              idle_accept_s;
  logic              taken_inc_s;
  logic              nottaken_inc_s;

  // Fetch works on 4-byte words, so the low two target bits are dropped.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

  // Classify the incoming record; only records seen while idle without a stop are acted on.
  always_comb begin
    is_branch_s    = rec_valid && is_unit(rec_unit, BRANCH_UNIT_ID);
    idle_accept_s  = (state_q == IDLE) && !rec_stop && is_branch_s;
    taken_inc_s    = idle_accept_s && rec_br_flag;
    nottaken_inc_s = idle_accept_s && !rec_br_flag;
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      flush_cnt_q      <= {FCNT_W{1'b0}};
      target_q         <= {PC_W{1'b0}};
      flush_q          <= 1'b0;
      fetch_stall_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Stop wins over a branch record arriving in the same cycle.
          if (rec_stop) begin
            state_q       <= HALT;
            halted_q      <= 1'b1;
            fetch_stall_q <= 1'b1;
          end else if (taken_inc_s) begin
            state_q       <= FLUSH;
            flush_cnt_q   <= FLUSH_LAST;
            target_q      <= word_align(rec_target);
            flush_q       <= 1'b1;
            fetch_stall_q <= 1'b1;
          end
        end
        FLUSH: begin
          // Records and stops here are wrong-path shadow and are ignored.
          if (flush_cnt_q == {FCNT_W{1'b0}}) begin
            state_q          <= REDIRECT;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q - {{(FCNT_W-1){1'b0}}, 1'b1};
          end
        end
        REDIRECT: begin
          if (redirect_ack) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            fetch_stall_q    <= 1'b0;
          end
        end
        HALT: begin
          halted_q      <= 1'b1;
          fetch_stall_q <= 1'b1;
        end
        default: begin
          state_q          <= IDLE;
          flush_q          <= 1'b0;
          fetch_stall_q    <= 1'b0;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (taken_inc_s),
    .count (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_nottaken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (nottaken_inc_s),
    .count (nottaken_cnt)
  );

  assign flush          = flush_q;
  assign fetch_stall    = fetch_stall_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = target_q;
  assign halted         = halted_q;

endmodule
